// File: rtl/up_counter_mod_if.sv
// Control and status bundle for up_counter_mod.
// The master side (stimulus or timer logic) drives enable, clear and load;
// the slave side is the counter itself and drives the count and status.
interface up_counter_mod_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              en_i;
  logic              clr_i;
  logic              load_i;
  logic [WIDTH-1:0]  d_i;
  logic [WIDTH-1:0]  q_o;
  logic              tc_o;
  logic              wrap_o;
  logic [WRAP_W-1:0] wraps_o;
  logic              load_err_o;

  modport master (
    output en_i, clr_i, load_i, d_i,
    input  q_o, tc_o, wrap_o, wraps_o, load_err_o
  );

  modport slave (
    input  en_i, clr_i, load_i, d_i,
    output q_o, tc_o, wrap_o, wraps_o, load_err_o
  );
endinterface

// File: rtl/up_counter_mod.sv
// up_counter_mod: parameterised up counter with enable, modulus wrap at
// MAX_COUNT, parallel load with range check, combinational cascade carry,
// a one-cycle wrap pulse and a saturating wrap tally.
// Optional build macro UP_COUNTER_SATURATE_EN: the count sticks at MAX_COUNT
// instead of wrapping; wrap never pulses and the tally stays at zero.
// Edge priority: async reset > clr > load > en > hold.
module up_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  up_counter_mod_if.slave   bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              loadErr_q, loadErr_d;
  logic              atMax;

  assign atMax = (count_q == MaxVal);

  // Next-state selection; the terminal compare (not natural overflow) decides the wrap
  always_comb begin
    count_d   = count_q;
    wrap_d    = 1'b0;
    wraps_d   = wraps_q;
    loadErr_d = loadErr_q;
    if (bus.clr_i) begin
      count_d   = '0;
      wraps_d   = '0;
      loadErr_d = 1'b0;
    end else if (bus.load_i) begin
      if (bus.d_i > MaxVal) begin
        count_d   = MaxVal;
        loadErr_d = 1'b1;
      end else begin
        count_d = bus.d_i;
      end
    end else if (bus.en_i) begin
      if (atMax) begin
`ifdef UP_COUNTER_SATURATE_EN
        count_d = MaxVal;
`else
        count_d = '0;
        wrap_d  = 1'b1;
        if (wraps_q != {WRAP_W{1'b1}}) begin
          wraps_d = wraps_q + 1'b1;
        end
`endif
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers, cleared immediately by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wrap_q    <= 1'b0;
      wraps_q   <= '0;
      loadErr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      wraps_q   <= wraps_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign bus.q_o        = count_q;
  assign bus.tc_o       = atMax && bus.en_i;
  assign bus.wrap_o     = wrap_q;
  assign bus.wraps_o    = wraps_q;
  assign bus.load_err_o = loadErr_q;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed testbench for up_counter_mod.
// Instance A: WIDTH=4, MAX_COUNT=15. Instance B: WIDTH=4, MAX_COUNT=9.
// Expected values follow the build: UP_COUNTER_SATURATE_EN selects the
// saturating expectations.
module tb_up_counter_mod;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  up_counter_mod_if #(.WIDTH(4), .WRAP_W(8)) busA ();
  up_counter_mod_if #(.WIDTH(4), .WRAP_W(8)) busB ();

  up_counter_mod #(.WIDTH(4), .MAX_COUNT(15), .WRAP_W(8)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  up_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .WRAP_W(8)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset held for two edges: everything reads zero, tc low
  task automatic test_reset();
    reset = 1'b1;
    busA.en_i = 1'b1;
    tick();
    tick();
    checks++;
    if (busA.q_o !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_q got=%0d exp=0", busA.q_o);
    end
    checks++;
    if (busA.tc_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_tc got=%b exp=0", busA.tc_o);
    end
    checks++;
    if (busA.wrap_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wrap got=%b exp=0", busA.wrap_o);
    end
    checks++;
    if (busA.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_wraps got=%0d exp=0", busA.wraps_o);
    end
    checks++;
    if (busA.load_err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_load_err got=%b exp=0", busA.load_err_o);
    end
  endtask

  // Modulus-16 free run for 20 edges on instance A
  task automatic test_free_run();
    logic [3:0] expQ;
    logic       expWrap;
    reset = 1'b0;
    busA.en_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef UP_COUNTER_SATURATE_EN
      expQ    = (i > 15) ? 4'd15 : 4'(i);
      expWrap = 1'b0;
`else
      expQ    = 4'(i % 16);
      expWrap = (i == 16);
`endif
      checks++;
      if (busA.q_o !== expQ) begin
        errors++; $display("[TB] FAIL free_run_q edge=%0d got=%0d exp=%0d", i, busA.q_o, expQ);
      end
      checks++;
      if (busA.tc_o !== (expQ == 4'd15)) begin
        errors++; $display("[TB] FAIL free_run_tc edge=%0d got=%b exp=%b", i, busA.tc_o, (expQ == 4'd15));
      end
      checks++;
      if (busA.wrap_o !== expWrap) begin
        errors++; $display("[TB] FAIL free_run_wrap edge=%0d got=%b exp=%b", i, busA.wrap_o, expWrap);
      end
    end
    checks++;
`ifdef UP_COUNTER_SATURATE_EN
    if (busA.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL free_run_wraps got=%0d exp=0", busA.wraps_o);
    end
`else
    if (busA.wraps_o !== 8'd1) begin
      errors++; $display("[TB] FAIL free_run_wraps got=%0d exp=1", busA.wraps_o);
    end
`endif
    busA.en_i = 1'b0;
  endtask

  // Modulus-10 run for 25 edges on instance B
  task automatic test_modulus();
    logic [3:0] expQ;
    logic       expWrap;
    busB.en_i = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
`ifdef UP_COUNTER_SATURATE_EN
      expQ    = (i > 9) ? 4'd9 : 4'(i);
      expWrap = 1'b0;
`else
      expQ    = 4'(i % 10);
      expWrap = (i == 10) || (i == 20);
`endif
      checks++;
      if (busB.q_o !== expQ) begin
        errors++; $display("[TB] FAIL modulus_q edge=%0d got=%0d exp=%0d", i, busB.q_o, expQ);
      end
      checks++;
      if (busB.wrap_o !== expWrap) begin
        errors++; $display("[TB] FAIL modulus_wrap edge=%0d got=%b exp=%b", i, busB.wrap_o, expWrap);
      end
    end
    checks++;
`ifdef UP_COUNTER_SATURATE_EN
    if (busB.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL modulus_wraps got=%0d exp=0", busB.wraps_o);
    end
`else
    if (busB.wraps_o !== 8'd2) begin
      errors++; $display("[TB] FAIL modulus_wraps got=%0d exp=2", busB.wraps_o);
    end
`endif
    busB.en_i = 1'b0;
  endtask

  // Clear, count to 6, hold through an enable gap, then step to 7
  task automatic test_enable_gating();
    busA.clr_i = 1'b1;
    busA.en_i  = 1'b1;
    tick();
    busA.clr_i = 1'b0;
    checks++;
    if (busA.q_o !== 4'd0) begin
      errors++; $display("[TB] FAIL gating_clr_q got=%0d exp=0", busA.q_o);
    end
    checks++;
    if (busA.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL gating_clr_wraps got=%0d exp=0", busA.wraps_o);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busA.q_o !== 4'd6) begin
      errors++; $display("[TB] FAIL gating_pre_q got=%0d exp=6", busA.q_o);
    end
    busA.en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busA.q_o !== 4'd6) begin
        errors++; $display("[TB] FAIL gating_hold_q cycle=%0d got=%0d exp=6", i, busA.q_o);
      end
      checks++;
      if (busA.tc_o !== 1'b0) begin
        errors++; $display("[TB] FAIL gating_hold_tc cycle=%0d got=%b exp=0", i, busA.tc_o);
      end
    end
    busA.en_i = 1'b1;
    tick();
    checks++;
    if (busA.q_o !== 4'd7) begin
      errors++; $display("[TB] FAIL gating_resume_q got=%0d exp=7", busA.q_o);
    end
    busA.en_i = 1'b0;
  endtask

  // Load beats enable, out-of-range load clamps and flags, clr beats load
  task automatic test_load_priority();
    busB.en_i   = 1'b1;
    busB.load_i = 1'b1;
    busB.d_i    = 4'd7;
    tick();
    checks++;
    if (busB.q_o !== 4'd7) begin
      errors++; $display("[TB] FAIL load_q got=%0d exp=7", busB.q_o);
    end
    checks++;
    if (busB.load_err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL load_err_inrange got=%b exp=0", busB.load_err_o);
    end
    busB.d_i = 4'd12;
    tick();
    checks++;
    if (busB.q_o !== 4'd9) begin
      errors++; $display("[TB] FAIL load_clamp_q got=%0d exp=9", busB.q_o);
    end
    checks++;
    if (busB.load_err_o !== 1'b1) begin
      errors++; $display("[TB] FAIL load_err_set got=%b exp=1", busB.load_err_o);
    end
    checks++;
    if (busB.wrap_o !== 1'b0) begin
      errors++; $display("[TB] FAIL load_no_wrap got=%b exp=0", busB.wrap_o);
    end
    checks++;
    if (busB.tc_o !== 1'b1) begin
      errors++; $display("[TB] FAIL load_tc_at_max got=%b exp=1", busB.tc_o);
    end
    checks++;
`ifdef UP_COUNTER_SATURATE_EN
    if (busB.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL load_wraps_hold got=%0d exp=0", busB.wraps_o);
    end
`else
    if (busB.wraps_o !== 8'd2) begin
      errors++; $display("[TB] FAIL load_wraps_hold got=%0d exp=2", busB.wraps_o);
    end
`endif
    busB.clr_i = 1'b1;
    busB.d_i   = 4'd3;
    tick();
    checks++;
    if (busB.q_o !== 4'd0) begin
      errors++; $display("[TB] FAIL clr_q got=%0d exp=0", busB.q_o);
    end
    checks++;
    if (busB.load_err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_load_err got=%b exp=0", busB.load_err_o);
    end
    checks++;
    if (busB.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL clr_wraps got=%0d exp=0", busB.wraps_o);
    end
    checks++;
    if (busB.wrap_o !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_wrap got=%b exp=0", busB.wrap_o);
    end
    busB.clr_i  = 1'b0;
    busB.load_i = 1'b0;
    busB.en_i   = 1'b0;
  endtask

  // Reset raised between edges clears at once; counting restarts from 0
  task automatic test_async_reset();
    busA.en_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
`ifdef UP_COUNTER_SATURATE_EN
    if (busA.q_o !== 4'd15 || busA.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL async_pre q=%0d wraps=%0d exp q=15 wraps=0", busA.q_o, busA.wraps_o);
    end
`else
    if (busA.q_o !== 4'd11 || busA.wraps_o !== 8'd1) begin
      errors++; $display("[TB] FAIL async_pre q=%0d wraps=%0d exp q=11 wraps=1", busA.q_o, busA.wraps_o);
    end
`endif
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busA.q_o !== 4'd0) begin
      errors++; $display("[TB] FAIL async_q got=%0d exp=0", busA.q_o);
    end
    checks++;
    if (busA.wraps_o !== 8'd0) begin
      errors++; $display("[TB] FAIL async_wraps got=%0d exp=0", busA.wraps_o);
    end
    checks++;
    if (busA.wrap_o !== 1'b0) begin
      errors++; $display("[TB] FAIL async_wrap got=%b exp=0", busA.wrap_o);
    end
    @(negedge clk);
    checks++;
    if (busA.q_o !== 4'd0) begin
      errors++; $display("[TB] FAIL async_held_q got=%0d exp=0", busA.q_o);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busA.q_o !== 4'd1) begin
      errors++; $display("[TB] FAIL async_recover_q got=%0d exp=1", busA.q_o);
    end
    busA.en_i = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    busA.en_i = 1'b0; busA.clr_i = 1'b0; busA.load_i = 1'b0; busA.d_i = 4'd0;
    busB.en_i = 1'b0; busB.clr_i = 1'b0; busB.load_i = 1'b0; busB.d_i = 4'd0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_modulus();
    test_enable_gating();
    test_load_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_counter_mod.md
# up_counter_mod

Parameterised synchronous up counter with enable, modulus wrap, parallel load and terminal-count carry. It is the counting-up counterpart of the team's 4-bit down counter. It shares the same clk/reset/en control style so both can be driven by the same stimulus and timer logic in the distribution designs. It also produces a cascade carry, a one-cycle wrap pulse and a saturating wrap tally for rate/timeout use.

## Interface
- WIDTH, 4, count register width in bits.
- MAX_COUNT, 2**WIDTH-1, terminal value; count range is 0..MAX_COUNT. Must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- WRAP_W, 8, width of the wrap tally.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  count enable; counter advances by 1 on each enabled edge.
- clr  input  1  synchronous clear of q, wraps and load_err.
- load  input  1  synchronous parallel load of d into q.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count.
- tc  output  1  combinational carry: (q == MAX_COUNT) && en; feeds en of the next cascaded stage.
- wrap  output  1  registered one-cycle pulse, high in the cycle after q wrapped MAX_COUNT -> 0.
- wraps  output  WRAP_W  number of wraps since reset/clr; saturates at all-ones.
- load_err  output  1  sticky; set when a load presents d > MAX_COUNT.

## Operation
- Per-edge priority: reset (async) > clr > load > en > hold.
- clr: q <= 0, wraps <= 0, load_err <= 0, wrap <= 0; en and load ignored that cycle.
- load (clr low): if d <= MAX_COUNT, q <= d; otherwise q <= MAX_COUNT and load_err <= 1. en is ignored that cycle, and load never pulses wrap or changes wraps.
- en (clr, load low):
  - If q < MAX_COUNT, q <= q + 1.
  - If q == MAX_COUNT, q <= 0, wrap <= 1, and wraps <= wraps + 1 unless wraps is all-ones, in which case it holds.
- Otherwise q, wraps and load_err hold. wrap is 0 on every edge that is not a wrap edge.
- Arithmetic is unsigned in WIDTH bits. The compare against MAX_COUNT decides the wrap, not natural overflow, so non-power-of-two moduli wrap correctly.
- tc depends only on the current q and en. It is not registered and has no dependency on load or clr.

## Timing
- Reset values: q = 0, wrap = 0, wraps = 0, load_err = 0. tc = 0 while reset is held, because q = 0 and MAX_COUNT >= 1.
- Reset asserted mid-count clears outputs without waiting for an edge. The first increment occurs on the first rising edge with reset low and en high.
- Count latency: one cycle from en sampled high to q updated.
- tc is high during the cycle q == MAX_COUNT with en high. On the following edge q = 0 and wrap = 1 for exactly one cycle.
- en held continuously gives a wrap period of MAX_COUNT+1 cycles. Back-to-back wraps cannot occur with MAX_COUNT >= 1.
- Cascade: a second stage with en = tc of the first increments exactly once per first-stage wrap, on the same edge.

## Configuration
- UP_COUNTER_SATURATE_EN defined: the counter saturates instead of wrapping. With en at q == MAX_COUNT, q holds at MAX_COUNT and tc stays high while en is high. wrap never pulses and wraps stays 0. clr and load still operate.
- UP_COUNTER_SATURATE_EN undefined: modulus wrap behaviour as described in Operation and Timing.

## Test plan
- Reset and free-run: WIDTH=4, MAX_COUNT=15. Assert reset 2 cycles, then en=1 for 20 cycles -> q goes 0,1,...,15,0,1,2,3. tc is high only while q=15. wrap pulses once, on the cycle after 15. wraps = 1.
- Non-power-of-two modulus: MAX_COUNT=9, en=1 for 25 cycles -> q cycles 0..9. Two wraps, wraps = 2, q = 5 at end.
- Enable gating: count to q=6, drop en for 3 cycles, raise en -> q holds at 6 through the gap, then advances to 7. tc stays 0.
- Load and priority:
  - MAX_COUNT=9, load d=7 with en=1 -> q=7, no increment that cycle.
  - load d=12 -> q=9, load_err=1.
  - clr together with load -> q=0, load_err=0, wraps=0.
- Async reset mid-count: at q=11, assert reset between edges -> q=0, wrap=0 and wraps=0 before the next edge. Recovery counts from 0.
- Saturation build (UP_COUNTER_SATURATE_EN, MAX_COUNT=15): en=1 for 20 cycles -> q stops at 15, tc=1 persistently, wrap never high, wraps=0.
